fetch_sequencer: RTL and testbench

//  Owns the instruction memory: shares its port between a program loader (write) and
//  the fetch path (read), and sequences fetch with PC, stall, branch-redirect and halt.

---
 rtl/fetch_sequencer_pkg.sv | 19 +
 rtl/fetch_sequencer_if_id.sv | 40 ++++
 rtl/fetch_sequencer.sv | 142 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch block.
//   fs_state_t    : sequencer state encoding (IDLE/LOAD/RUN/HALT)
//   HALT_WORD_ENC : "JMP -1" encoding that terminates RUN
//   NOP_WORD      : value placed in IF/ID on a bubble
//   PC_STEP       : byte increment between sequential fetches
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } fs_state_t;

    localparam logic [31:0] HALT_WORD_ENC = 32'hA800FFFF;
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
    localparam int unsigned PC_STEP       = 4;

endpackage

// File: rtl/fetch_sequencer_if_id.sv
// IF/ID pipeline register.
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   flush             : replace contents with a bubble (NOP, valid=0); PC field holds
//   load              : capture instr_d / pc_d and mark valid
//   instr_d, pc_d     : next instruction word and its PC+4
//   if_instr, if_pc   : registered instruction and PC+4 seen by decode
//   if_valid          : 1 = real instruction, 0 = bubble
// With neither flush nor load asserted the register holds (freeze).
module if_id_pipe_reg
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic [N-1:0] instr_d,
    input  logic [N-1:0] pc_d,
    output logic [N-1:0] if_instr,
    output logic [N-1:0] if_pc,
    output logic         if_valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_instr <= '0;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else if (flush) begin
            if_instr <= N'(NOP_WORD);
            if_valid <= 1'b0;
        end else if (load) begin
            if_instr <= instr_d;
            if_pc    <= pc_d;
            if_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer.
// Owns the single instruction-memory port, sharing it between a streaming program
// loader (writes) and the fetch path (reads), and drives the IF/ID register.
//   clk, rst      : clock (rising edge), asynchronous active-low reset
//   start         : pulse, begin RUN from PC=0 (accepted in IDLE and HALT)
//   ld_valid/ld_data/ld_last/ld_ready : loader beat handshake
//   ld_err        : sticky, the loader wrapped past the last memory word
//   freeze        : hazard stall, hold PC and IF/ID
//   branch_taken/branch_addr : redirect from decode (byte address)
//   imem_addr/imem_we/imem_wdata/imem_rdata : memory port (sync write, comb read)
//   if_instr/if_pc/if_valid : IF/ID register (instruction, PC+4, valid)
//   halted        : sequencer is in HALT
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned    N         = 32,
    parameter int unsigned    ADDR_W    = 7,
    parameter int unsigned    DEPTH     = 128,
    parameter logic [N-1:0]   HALT_WORD = N'(HALT_WORD_ENC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [N-1:0]      ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_err,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [N-1:0]      branch_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [N-1:0]      imem_wdata,
    input  logic [N-1:0]      imem_rdata,
    output logic [N-1:0]      if_instr,
    output logic [N-1:0]      if_pc,
    output logic              if_valid,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fs_state_t         state;
    logic [N-1:0]      pc;
    logic [ADDR_W-1:0] ld_cnt;
    logic [N-1:0]      pc_plus4;
    logic              ld_accept;
    logic              fetch_go;
    logic              pipe_flush;

    assign pc_plus4 = pc + N'(PC_STEP);

    // Memory port mux: the loader owns the port in IDLE/LOAD, fetch owns it otherwise.
    always_comb begin
        ld_ready   = (state == ST_IDLE) || (state == ST_LOAD);
        imem_we    = ld_ready && ld_valid;
        imem_wdata = ld_data;
        imem_addr  = ld_ready ? ld_cnt : pc[ADDR_W+1:2];
    end

    assign ld_accept = ld_valid && ld_ready;

    // Branch beats freeze; HALT streams bubbles every cycle.
    always_comb begin
        fetch_go   = (state == ST_RUN) && !branch_taken && !freeze;
        pipe_flush = ((state == ST_RUN) && branch_taken) || (state == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            pc     <= '0;
            ld_cnt <= '0;
            ld_err <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_LOAD: begin
                    // A loader beat always takes precedence over start.
                    if (ld_accept) begin
                        if (ld_last) begin
                            ld_cnt <= '0;
                            state  <= ST_IDLE;
                        end else if (ld_cnt == LAST_ADDR) begin
                            ld_cnt <= '0;
                            ld_err <= 1'b1;
                            state  <= ST_LOAD;
                        end else begin
                            ld_cnt <= ld_cnt + ADDR_W'(1);
                            state  <= ST_LOAD;
                        end
                    end else if (start && (state == ST_IDLE)) begin
                        state <= ST_RUN;
                        pc    <= '0;
                    end
                end

                ST_RUN: begin
                    if (branch_taken) begin
                        pc <= branch_addr;
                    end else if (!freeze) begin
                        pc <= pc_plus4;
                        // The halt word itself is still issued into IF/ID.
                        if (imem_rdata == HALT_WORD) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                    end
                end

                ST_HALT: begin
                    if (start) begin
                        state  <= ST_RUN;
                        pc     <= '0;
                        halted <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    if_id_pipe_reg #(
        .N(N)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .flush    (pipe_flush),
        .load     (fetch_go),
        .instr_d  (imem_rdata),
        .pc_d     (pc_plus4),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .if_valid (if_valid)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [31:0] HW = 32'hA800FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        ld_err;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [6:0]  imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        halted;

    logic [31:0] mem [128];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        string       nm;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];

    fetch_sequencer #(
        .N(32),
        .ADDR_W(7),
        .DEPTH(128),
        .HALT_WORD(32'hA800FFFF)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_err(ld_err),
        .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
        .imem_rdata(imem_rdata),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory: synchronous write, combinational read.
    initial for (int i = 0; i < 128; i++) mem[i] = '0;
    always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;
    assign imem_rdata = mem[imem_addr];

    // Monitor: compares IF/ID and halted against the entry due this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (e.cyc != cyc || if_instr !== e.instr || if_pc !== e.pc ||
                    if_valid !== e.valid || halted !== e.halted) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d(due %0d): got instr=%h pc=%h v=%b h=%b, want instr=%h pc=%h v=%b h=%b",
                             e.nm, cyc, e.cyc, if_instr, if_pc, if_valid, halted,
                             e.instr, e.pc, e.valid, e.halted);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string nm, input logic [31:0] ei, input logic [31:0] ep,
                        input logic ev, input logic eh);
        exp_t e;
        e.cyc = cyc + 1; e.nm = nm; e.instr = ei; e.pc = ep; e.valid = ev; e.halted = eh;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_instr"}, if_instr, 32'h0);
        chk({tag, "_pc"}, if_pc, 32'h0);
        chk({tag, "_valid"}, {31'b0, if_valid}, 32'h0);
        chk({tag, "_halted"}, {31'b0, halted}, 32'h0);
        chk({tag, "_ld_err"}, {31'b0, ld_err}, 32'h0);
        chk({tag, "_ld_ready"}, {31'b0, ld_ready}, 32'h1);
        chk({tag, "_addr"}, {25'b0, imem_addr}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p [11];
        for (int i = 0; i < 10; i++) p[i] = 32'h0000_1100 + 32'(i);
        p[10] = HW;

        // Power-on reset.
        #1;
        check_reset_state("rst0");
        tick();
        #2 rst = 1'b1;
        tick();

        // Load A,B,HALT; start on the first beat must be ignored.
        ld_valid = 1'b1; ld_data = 32'hAAAA_0001; start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_wins_ready", {31'b0, ld_ready}, 32'h1);
        chk("load_cnt1", {25'b0, imem_addr}, 32'h1);
        ld_data = 32'hBBBB_0002;
        tick();
        ld_data = HW; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("load_mem0", mem[0], 32'hAAAA_0001);
        chk("load_mem1", mem[1], 32'hBBBB_0002);
        chk("load_mem2", mem[2], HW);
        chk("load_cnt0", {25'b0, imem_addr}, 32'h0);
        chk("load_idle_ready", {31'b0, ld_ready}, 32'h1);

        // Run: halt word at word 2.
        start = 1'b1;
        step("r1_start", 32'h0, 32'h0, 1'b0, 1'b0);
        start = 1'b0;
        step("r1_f0", 32'hAAAA_0001, 32'd4, 1'b1, 1'b0);
        step("r1_f1", 32'hBBBB_0002, 32'd8, 1'b1, 1'b0);
        step("r1_halt_issue", HW, 32'd12, 1'b1, 1'b1);
        step("r1_bubble0", 32'h0, 32'd12, 1'b0, 1'b1);
        step("r1_bubble1", 32'h0, 32'd12, 1'b0, 1'b1);
        drain();

        // Reset from HALT.
        rst = 1'b0;
        #1;
        check_reset_state("rst1");
        #2 rst = 1'b1;
        tick();

        // DEPTH+1 beats without ld_last.
        for (int i = 0; i <= 128; i++) begin
            ld_valid = 1'b1; ld_data = 32'h5000_0000 + 32'(i); ld_last = 1'b0;
            tick();
            if (i == 126) chk("ovf_err_before", {31'b0, ld_err}, 32'h0);
            if (i == 127) chk("ovf_err_set", {31'b0, ld_err}, 32'h1);
        end
        ld_data = 32'h5000_0081; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("ovf_mem0", mem[0], 32'h5000_0080);
        chk("ovf_mem1", mem[1], 32'h5000_0081);
        chk("ovf_mem2", mem[2], 32'h5000_0002);
        chk("ovf_mem127", mem[127], 32'h5000_007F);
        chk("ovf_idle_addr", {25'b0, imem_addr}, 32'h0);

        // Load 11-word program ending in the halt word.
        for (int i = 0; i < 11; i++) begin
            ld_valid = 1'b1; ld_data = p[i]; ld_last = (i == 10);
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("ld_err_sticky", {31'b0, ld_err}, 32'h1);

        start = 1'b1;
        step("r2_start", 32'h0, 32'h0, 1'b0, 1'b0);
        start = 1'b0;
        step("r2_seq4", p[0], 32'd4, 1'b1, 1'b0);
        step("r2_seq8", p[1], 32'd8, 1'b1, 1'b0);
        step("r2_seq12", p[2], 32'd12, 1'b1, 1'b0);
        step("r2_seq16", p[3], 32'd16, 1'b1, 1'b0);
        branch_taken = 1'b1; branch_addr = 32'h0;
        step("r2_br0_flush", 32'h0, 32'd16, 1'b0, 1'b0);
        branch_taken = 1'b0;
        step("r2_re4", p[0], 32'd4, 1'b1, 1'b0);
        step("r2_re8", p[1], 32'd8, 1'b1, 1'b0);
        freeze = 1'b1;
        step("r2_frz1", p[1], 32'd8, 1'b1, 1'b0);
        step("r2_frz2", p[1], 32'd8, 1'b1, 1'b0);
        chk("r2_frz_pc_hold", {25'b0, imem_addr}, 32'd2);
        freeze = 1'b0;
        step("r2_resume12", p[2], 32'd12, 1'b1, 1'b0);
        step("r2_resume16", p[3], 32'd16, 1'b1, 1'b0);
        branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'h20;
        step("r2_br20_flush", 32'h0, 32'd16, 1'b0, 1'b0);
        branch_taken = 1'b0; freeze = 1'b0;
        chk("r2_br20_addr", {25'b0, imem_addr}, 32'd8);
        step("r2_t24", p[8], 32'h24, 1'b1, 1'b0);
        step("r2_t28", p[9], 32'h28, 1'b1, 1'b0);
        step("r2_halt_issue", HW, 32'h2C, 1'b1, 1'b1);
        step("r2_bubble0", 32'h0, 32'h2C, 1'b0, 1'b1);
        branch_taken = 1'b1; branch_addr = 32'h40; freeze = 1'b1;
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        chk("halt_no_ld_ready", {31'b0, ld_ready}, 32'h0);
        chk("halt_no_we", {31'b0, imem_we}, 32'h0);
        step("r2_bubble_ign", 32'h0, 32'h2C, 1'b0, 1'b1);
        chk("halt_pc_hold", {25'b0, imem_addr}, 32'd11);
        chk("halt_mem0_kept", mem[0], p[0]);
        branch_taken = 1'b0; freeze = 1'b0; ld_valid = 1'b0;

        // Restart from HALT, then reset mid-RUN.
        start = 1'b1;
        step("r3_start", 32'h0, 32'h2C, 1'b0, 1'b0);
        start = 1'b0;
        step("r3_f4", p[0], 32'd4, 1'b1, 1'b0);
        step("r3_f8", p[1], 32'd8, 1'b1, 1'b0);
        drain();
        rst = 1'b0;
        #1;
        check_reset_state("rst_run");
        #2 rst = 1'b1;
        tick();
        chk("post_rst_mem1", mem[1], p[1]);

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
